// File: rtl/prover_ctrl_pkg.sv
// Shared types and sizing helpers for the prover layer/round controllers.
package prover_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_SHIFT
  } shuf_ctrl_state_t;

  // Sumcheck rounds needed to fold a layer of ngates gates down to one.
  function automatic int calc_nrounds(input int ngates);
    return $clog2(ngates);
  endfunction

  // Width of a round index; never narrower than one bit.
  function automatic int calc_round_w(input int ngates);
    int nr;
    nr = $clog2(ngates);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

endpackage

// File: rtl/prover_wdog.sv
// Watchdog counter: cleared on entry to a wait, counts while enabled, flags the
// cycle that completes TIMEOUT waiting cycles.
module prover_wdog #(
  parameter int  TIMEOUT = 64,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_tc
);

  logic [TW-1:0] r_cnt;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The count is 0 in the first waiting cycle, so TIMEOUT-1 marks the last one.
  assign o_tc = (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/prover_shuffle_ctrl.sv
// Sumcheck round sequencer for one prover_shuffle_v instance: restart, then
// alternate COMPUTE / SHIFT until every round of the layer is consumed.
module prover_shuffle_ctrl
  import prover_ctrl_pkg::*;
#(
  parameter int  NGATES  = 15,
  parameter int  TIMEOUT = 64,
  localparam int NROUNDS = calc_nrounds(NGATES),
  localparam int RW      = calc_round_w(NGATES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_step_done,
  input  logic          i_shuf_ready_pulse,
  output logic          o_shuf_en,
  output logic          o_shuf_restart,
  output logic          o_round_valid,
  output logic [RW-1:0] o_round,
  output logic          o_last_round,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS - 1);

  shuf_ctrl_state_t r_state, w_state_nxt;
  logic          r_shuf_en, r_shuf_restart, r_round_valid, r_last_round;
  logic          r_busy, r_done, r_err;
  logic [RW-1:0] r_round, w_round_nxt;
  logic          w_shuf_en_nxt, w_restart_nxt, w_round_valid_nxt, w_done_nxt, w_err_nxt;
  logic          w_wd_clr, w_wd_en, w_wd_tc;

  prover_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_wd_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_wd_en),
    .o_tc       (w_wd_tc)
  );

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_round_nxt       = r_round;
    w_shuf_en_nxt     = 1'b0;
    w_restart_nxt     = 1'b0;
    w_round_valid_nxt = 1'b0;
    w_done_nxt        = 1'b0;
    w_err_nxt         = r_err;
    w_wd_clr          = 1'b0;
    w_wd_en           = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_round_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt   = ST_LOAD;
            w_shuf_en_nxt = 1'b1;
            w_restart_nxt = 1'b1;
            w_err_nxt     = 1'b0;
            w_round_nxt   = '0;
            w_wd_clr      = 1'b1;
          end
        end
        ST_LOAD, ST_SHIFT: begin
          w_wd_en = 1'b1;
          // A pulse during the command cycle completes an older operation.
          if (i_shuf_ready_pulse && !r_shuf_en) begin
            w_state_nxt       = ST_COMPUTE;
            w_round_valid_nxt = 1'b1;
          end else if (w_wd_tc) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end
        end
        ST_COMPUTE: begin
          w_round_valid_nxt = 1'b1;
          if (i_step_done) begin
            w_round_valid_nxt = 1'b0;
            if (r_round == LAST_ROUND) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt   = ST_SHIFT;
              w_round_nxt   = r_round + 1'b1;
              w_shuf_en_nxt = 1'b1;
              w_wd_clr      = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_round        <= '0;
      r_shuf_en      <= 1'b0;
      r_shuf_restart <= 1'b0;
      r_round_valid  <= 1'b0;
      r_last_round   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_round        <= w_round_nxt;
      r_shuf_en      <= w_shuf_en_nxt;
      r_shuf_restart <= w_restart_nxt;
      r_round_valid  <= w_round_valid_nxt;
      r_last_round   <= w_round_valid_nxt && (w_round_nxt == LAST_ROUND);
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_done         <= w_done_nxt;
      r_err          <= w_err_nxt;
    end
  end

  assign o_shuf_en      = r_shuf_en;
  assign o_shuf_restart = r_shuf_restart;
  assign o_round_valid  = r_round_valid;
  assign o_round        = r_round;
  assign o_last_round   = r_last_round;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: doc/prover_shuffle_ctrl.md
# prover_shuffle_ctrl

Sequences one `prover_shuffle_v` instance through all sumcheck rounds of one circuit layer. On `start`, it issues the shuffle's restart (initial load of V). It then alternates between presenting the current V arrays to the round-compute logic and commanding one shuffle/halving step, until $clog2(ngates) rounds complete. The block sits between the layer controller (`start`/`done`/`err`) and the shuffle datapath (`en`/`restart`/`ready_pulse`), and adds a watchdog against a stalled shuffle.

## Interface
- `ngates`, 15: gate count of the layer; must match the shuffle instance; `nrounds = $clog2(ngates)`, must be ≥ 1.
- `timeout`, 64: maximum cycles to wait for `shuf_ready_pulse` after a restart or step.
- Derived: `RW = max(1, $clog2(nrounds))` is the width of `round`; `TW = $clog2(timeout+1)` is the watchdog width.
- `clk`  in  1  the single clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  pulse that begins a layer; accepted only in IDLE.
- `abort`  in  1  forces a return to IDLE from any state.
- `step_done`  in  1  pulse from compute logic: the current round is consumed and the challenge is applied.
- `shuf_ready_pulse`  in  1  the shuffle's completion pulse.
- `shuf_en`  out  1  enable to the shuffle; wired as `en`.
- `shuf_restart`  out  1  restart to the shuffle; asserted together with `shuf_en`.
- `round_valid`  out  1  the shuffle's V arrays are valid for the current round.
- `round`  out  RW  current round index, 0..nrounds-1.
- `last_round`  out  1  `round == nrounds-1` while `round_valid` is high.
- `busy`  out  1  the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when a layer completes normally.
- `err`  out  1  sticky watchdog error.

## Operation
- States: IDLE, LOAD, COMPUTE, SHIFT. All outputs are registered.
- IDLE, on `start`:
  - go to LOAD;
  - `shuf_en` and `shuf_restart` are both 1 for the first LOAD cycle;
  - clear `err` and `round`.
- LOAD and SHIFT:
  - the watchdog is cleared on entry and increments every cycle;
  - `shuf_ready_pulse` is honoured only when `shuf_en` is 0, i.e. from the second cycle onward; a pulse in the command cycle belongs to a prior operation and is ignored;
  - a valid pulse moves the FSM to COMPUTE.
- COMPUTE:
  - `round_valid` is 1;
  - on `step_done` with `round < nrounds-1`: go to SHIFT, increment `round`, and drive `shuf_en` = 1 (restart 0) for the first SHIFT cycle;
  - on `step_done` with `round == nrounds-1`: go to IDLE and pulse `done`.
- Watchdog: if the counter reaches `timeout` in LOAD or SHIFT without a valid pulse:
  - set `err` (sticky), go to IDLE, and do not pulse `done`;
  - `err` clears only on `rst` or on an accepted `start`.
- `abort`: from any state, go to IDLE on the next edge; clear `round`, `round_valid` and `shuf_en`; no `done`; `err` is unchanged. `abort` takes priority over `start`, `step_done` and `shuf_ready_pulse` in the same cycle.
- Ignored inputs:
  - `start` outside IDLE;
  - `step_done` outside COMPUTE;
  - `shuf_ready_pulse` outside LOAD/SHIFT.
- Single round (`nrounds == 1`): no SHIFT ever occurs; `done` follows the first `step_done`.

## Timing
- Reset: every output is 0, `round` = 0, state is IDLE.
- `start` at edge N:
  - `busy`, `shuf_en` and `shuf_restart` are 1 in cycle N+1;
  - `shuf_en` and `shuf_restart` drop in cycle N+2.
- A valid `shuf_ready_pulse` at edge M gives `round_valid` = 1 in cycle M+1.
- `step_done` at edge K:
  - `round_valid` = 0 in cycle K+1;
  - in that same cycle, either `shuf_en` = 1 with `round` incremented, or `done` = 1 with `busy` = 0.
- Controller overhead is 1 cycle per transition. The shuffle latency (plstages-dependent) is not assumed; it is bounded only by `timeout`.
- Back-to-back layers: `start` may arrive in the same cycle that `done` is high; it is accepted.

## Structure
- Shared package `prover_ctrl_pkg` holds:
  - the state enum `shuf_ctrl_state_t`;
  - the `nrounds`/RW helper function, which the layer controller and compute logic reuse.
- One natural sub-module, `prover_wdog`: a loadable up-counter with clear, enable and a terminal-count flag, parameterized by `timeout`.
- The FSM, `round` counter and output registers live in the top module.

## Test plan
Defaults are `ngates` = 15 (nrounds = 4) and `timeout` = 64. The shuffle model pulses `ready_pulse` 3 cycles after `shuf_en`.

- Reset: hold `rst` for 2 cycles mid-COMPUTE. Required: all outputs 0, `round` = 0, `busy` = 0 the cycle after.
- Full layer: `start`, with `step_done` 5 cycles after each `round_valid` rise. Required:
  - exactly 1 restart and 3 non-restart `shuf_en` pulses;
  - `round` steps through 0,1,2,3;
  - `last_round` is high only in round 3;
  - exactly one `done`, one cycle after the 4th `step_done`.
- Ignored inputs: `start` during SHIFT, `step_done` during LOAD, and `ready_pulse` coincident with `shuf_en`. Required: the sequence of the full-layer scenario is unchanged.
- Watchdog: suppress `ready_pulse` after the restart. Required:
  - `err` = 1 and `busy` = 0 exactly 64 cycles after `shuf_en`;
  - `done` stays 0;
  - the next `start` clears `err`.
- Abort: assert `abort` together with `step_done` in round 2. Required: IDLE next cycle, `round` = 0, no `shuf_en`, no `done`; the following `start` completes normally.
- Small layer: `ngates` = 2 (nrounds = 1). Required: one restart, zero steps, `done` one cycle after the first `step_done`. Rerun the full-layer scenario with `ngates` = 16 and check for 4 rounds.
